// File: rtl/mac_dot_driver_if.sv
// Handshake and MAC-core bus between mac_dot_driver and its environment.
// The slave modport is the driver's view; the master modport is the environment's.
interface mac_dot_driver_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_len;
    logic [31:0] cmd_acc_init;
    logic        op_valid;
    logic        op_ready;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        mac_ce;
    logic        mac_continue;
    logic        mac_start;
    logic [31:0] mac_a;
    logic [31:0] mac_b;
    logic [31:0] mac_acc_in;
    logic [31:0] mac_acc_out;
    logic        mac_acc_vld;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic        res_err;

    modport slave (
        input  cmd_valid, cmd_len, cmd_acc_init, op_valid, op_a, op_b,
               mac_acc_out, mac_acc_vld, res_ready,
        output cmd_ready, op_ready, mac_ce, mac_continue, mac_start,
               mac_a, mac_b, mac_acc_in, res_valid, res_data, res_err
    );

    modport master (
        output cmd_valid, cmd_len, cmd_acc_init, op_valid, op_a, op_b,
               mac_acc_out, mac_acc_vld, res_ready,
        input  cmd_ready, op_ready, mac_ce, mac_continue, mac_start,
               mac_a, mac_b, mac_acc_in, res_valid, res_data, res_err
    );
endinterface

// File: rtl/mac_dot_driver.sv
// Sequences cmd_len 4-lane uint8 dot-product beats through an external MAC core.
// Optional WAIT-state watchdog: define MAC_DOT_DRIVER_TIMEOUT_EN (limit TIMEOUT_CYC).
module mac_dot_driver #(
    parameter int TIMEOUT_CYC = 15
) (
    input  logic             ap_clk,
    input  logic             ap_rst,
    mac_dot_driver_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, FETCH, ISSUE, WAIT, DONE} state_t;

    state_t      state_q;
    logic [7:0]  beats_q;
    logic [31:0] acc_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic        cmd_ready_q;
    logic        op_ready_q;
    logic        start_q;
    logic        res_valid_q;

`ifdef MAC_DOT_DRIVER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1) + 1;
    logic [TW-1:0] tmo_q;
    logic          err_q;
    assign bus.res_err = err_q;
`else
    logic unused_timeout_cyc;
    assign unused_timeout_cyc = ^TIMEOUT_CYC;
    assign bus.res_err        = 1'b0;
`endif

    assign bus.mac_ce       = ~ap_rst;
    assign bus.mac_continue = ~ap_rst;
    assign bus.cmd_ready    = cmd_ready_q;
    assign bus.op_ready     = op_ready_q;
    assign bus.mac_start    = start_q;
    assign bus.mac_a        = a_q;
    assign bus.mac_b        = b_q;
    assign bus.mac_acc_in   = acc_q;
    assign bus.res_valid    = res_valid_q;
    assign bus.res_data     = acc_q;

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q     <= IDLE;
            beats_q     <= '0;
            acc_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            cmd_ready_q <= 1'b1;
            op_ready_q  <= 1'b0;
            start_q     <= 1'b0;
            res_valid_q <= 1'b0;
`ifdef MAC_DOT_DRIVER_TIMEOUT_EN
            tmo_q       <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            start_q <= 1'b0;
            case (state_q)
                IDLE: if (bus.cmd_valid) begin
                    beats_q     <= bus.cmd_len;
                    acc_q       <= bus.cmd_acc_init;
                    cmd_ready_q <= 1'b0;
                    if (bus.cmd_len == 8'd0) begin
                        state_q     <= DONE;
                        res_valid_q <= 1'b1;
                    end else begin
                        state_q    <= FETCH;
                        op_ready_q <= 1'b1;
                    end
                end
                FETCH: if (bus.op_valid) begin
                    a_q        <= bus.op_a;
                    b_q        <= bus.op_b;
                    op_ready_q <= 1'b0;
                    start_q    <= 1'b1;
                    state_q    <= ISSUE;
                end
                ISSUE: begin
                    state_q <= WAIT;
`ifdef MAC_DOT_DRIVER_TIMEOUT_EN
                    tmo_q   <= '0;
`endif
                end
                // Operand and accumulator registers are frozen here, so the core
                // sees stable inputs until its done pulse is taken.
                WAIT: if (bus.mac_acc_vld) begin
                    acc_q   <= bus.mac_acc_out;
                    beats_q <= beats_q - 8'd1;
                    if (beats_q == 8'd1) begin
                        state_q     <= DONE;
                        res_valid_q <= 1'b1;
                    end else begin
                        state_q    <= FETCH;
                        op_ready_q <= 1'b1;
                    end
                end
`ifdef MAC_DOT_DRIVER_TIMEOUT_EN
                else if (tmo_q == TW'(TIMEOUT_CYC)) begin
                    state_q     <= DONE;
                    res_valid_q <= 1'b1;
                    err_q       <= 1'b1;
                end else begin
                    tmo_q <= tmo_q + TW'(1);
                end
`endif
                DONE: if (bus.res_ready) begin
                    state_q     <= IDLE;
                    res_valid_q <= 1'b0;
                    cmd_ready_q <= 1'b1;
`ifdef MAC_DOT_DRIVER_TIMEOUT_EN
                    err_q       <= 1'b0;
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mac_dot_driver.sv
// Directed-vector bench for mac_dot_driver with a two-cycle MAC core model and
// a result scoreboard checked by an independent monitor.
module tb_mac_dot_driver;
    logic ap_clk = 1'b0;
    logic ap_rst = 1'b1;
    always #5 ap_clk = ~ap_clk;

    mac_dot_driver_if bus();

    mac_dot_driver #(.TIMEOUT_CYC(15)) dut (
        .ap_clk (ap_clk),
        .ap_rst (ap_rst),
        .bus    (bus)
    );

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    int          nstart = 0;
    int          stall  = 0;
    logic        core_en = 1'b1;
    logic        inj     = 1'b0;
    logic [31:0] va[4];
    logic [31:0] vb[4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] dot(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] acc);
        logic [31:0] s;
        s = acc;
        for (int i = 0; i < 4; i++) s = s + {24'd0, a[8*i +: 8]} * {24'd0, b[8*i +: 8]};
        return s;
    endfunction

    initial forever begin
        @(posedge ap_clk);
        cyc = cyc + 1;
    end

    // Core model: done pulse two cycles after mac_start; inj forces a stray pulse.
    initial begin
        logic        pend;
        logic [31:0] pend_val;
        pend = 1'b0;
        pend_val = '0;
        bus.mac_acc_vld = 1'b0;
        bus.mac_acc_out = '0;
        forever begin
            @(posedge ap_clk);
            bus.mac_acc_vld <= core_en & (pend | inj);
            bus.mac_acc_out <= pend ? pend_val : 32'hBAD0BAD0;
            pend     = bus.mac_start;
            pend_val = dot(bus.mac_a, bus.mac_b, bus.mac_acc_in);
        end
    end

    // Monitor: result scoreboard, res_ready stalls, MAC input stability window.
    initial begin
        logic        seen, win;
        logic [31:0] hold, ra, rb, racc;
        seen = 1'b0; win = 1'b0; hold = '0; ra = '0; rb = '0; racc = '0;
        bus.res_ready = 1'b0;
        forever begin
            @(negedge ap_clk);
            if (bus.mac_start) nstart++;
            if (ap_rst) begin
                seen = 1'b0;
                win  = 1'b0;
                bus.res_ready = 1'b0;
            end else begin
                if (bus.mac_start) begin
                    win = 1'b1; ra = bus.mac_a; rb = bus.mac_b; racc = bus.mac_acc_in;
                end else if (win) begin
                    chk("mac_a_stable", bus.mac_a, ra);
                    chk("mac_b_stable", bus.mac_b, rb);
                    chk("mac_acc_in_stable", bus.mac_acc_in, racc);
                    if (bus.mac_acc_vld || bus.res_valid) win = 1'b0;
                end
                if (!bus.res_valid) begin
                    bus.res_ready = 1'b0;
                end else if (sb.size() == 0) begin
                    chk("unexpected_res_valid", bus.res_valid, 0);
                    bus.res_ready = 1'b1;
                end else begin
                    if (!seen) begin
                        seen = 1'b1;
                        hold = bus.res_data;
                        if (sb[0].cyc >= 0) chk("res_cycle", cyc, sb[0].cyc);
                    end else begin
                        chk("res_data_stable", bus.res_data, hold);
                    end
                    if (stall > 0) begin
                        stall--;
                        bus.res_ready = 1'b0;
                    end else begin
                        chk("res_data", bus.res_data, sb[0].data);
                        chk("res_err", bus.res_err, sb[0].err);
                        void'(sb.pop_front());
                        bus.res_ready = 1'b1;
                        seen = 1'b0;
                    end
                end
            end
        end
    end

    task automatic send_cmd(input int len, input logic [31:0] init, input logic [31:0] exp_data,
                            input logic exp_err, input int lat, input bit push);
        int t, n0;
        t = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_len = 8'(len);
        bus.cmd_acc_init = init;
        while (!bus.cmd_ready && t < 200) begin @(negedge ap_clk); t++; end
        chk("cmd_accept_timeout", (t >= 200), 0);
        @(posedge ap_clk); #1;
        n0 = cyc;
        bus.cmd_valid = 1'b0;
        if (push) sb.push_back('{exp_data, exp_err, (lat < 0) ? -1 : n0 - 1 + lat});
    endtask

    task automatic feed(input int n, input int gap_at, input int gap);
        int t;
        for (int i = 0; i < n; i++) begin
            if (i == gap_at) begin
                t = 0;
                while (!bus.op_ready && t < 200) begin @(negedge ap_clk); t++; end
                for (int g = 0; g < gap; g++) begin
                    inj = (g == 0);
                    @(negedge ap_clk);
                end
                inj = 1'b0;
            end
            bus.op_valid = 1'b1;
            bus.op_a = va[i];
            bus.op_b = vb[i];
            t = 0;
            while (!bus.op_ready && t < 200) begin @(negedge ap_clk); t++; end
            chk("op_accept_timeout", (t >= 200), 0);
            @(posedge ap_clk); #1;
            bus.op_valid = 1'b0;
            @(negedge ap_clk);
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 300) begin @(negedge ap_clk); t++; end
        repeat (2) @(negedge ap_clk);
        chk("drained", sb.size(), 0);
    endtask

    initial begin
        int s;
        bus.cmd_valid = 1'b0; bus.cmd_len = '0; bus.cmd_acc_init = '0;
        bus.op_valid = 1'b0; bus.op_a = '0; bus.op_b = '0;

        repeat (2) @(negedge ap_clk);
        chk("rst_mac_start", bus.mac_start, 0);
        chk("rst_res_valid", bus.res_valid, 0);
        chk("rst_res_err", bus.res_err, 0);
        chk("rst_op_ready", bus.op_ready, 0);
        chk("rst_mac_a", bus.mac_a, 0);
        chk("rst_mac_b", bus.mac_b, 0);
        chk("rst_mac_acc_in", bus.mac_acc_in, 0);
        chk("rst_res_data", bus.res_data, 0);
        chk("rst_mac_ce", bus.mac_ce, 0);
        ap_rst = 1'b0;
        @(negedge ap_clk);
        chk("post_rst_cmd_ready", bus.cmd_ready, 1);
        chk("post_rst_mac_ce", bus.mac_ce, 1);
        chk("post_rst_mac_continue", bus.mac_continue, 1);

        // Single beat: 1+2+3+4 = 10 at cycle 5.
        va[0] = 32'h04030201; vb[0] = 32'h01010101;
        fork send_cmd(1, 32'd0, 32'd10, 1'b0, 5, 1'b1); feed(1, -1, 0); join
        drain();

        // Three beats of 4*(2*2) on top of 100 -> 148 at cycle 13.
        for (int i = 0; i < 3; i++) begin va[i] = 32'h02020202; vb[i] = 32'h02020202; end
        fork send_cmd(3, 32'd100, 32'd148, 1'b0, 13, 1'b1); feed(3, -1, 0); join
        drain();

        // Zero-length command returns the initial accumulator without touching the core.
        s = nstart;
        send_cmd(0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1, 1'b1);
        drain();
        chk("len0_no_mac_start", nstart, s);

        // 480 + 260100 on 0xFFFFFFF0 wraps to 0x3F9D4; operand gap with a stray done pulse.
        va[0] = 32'h10203040; vb[0] = 32'h01020304;
        va[1] = 32'hFFFFFFFF; vb[1] = 32'hFFFFFFFF;
        stall = 3;
        fork send_cmd(2, 32'hFFFFFFF0, 32'h0003F9D4, 1'b0, -1, 1'b1); feed(2, 1, 5); join
        drain();

        // Reset during WAIT of beat 2 of 4: partial result dropped.
        s = nstart;
        for (int i = 0; i < 4; i++) begin va[i] = 32'h11111111; vb[i] = 32'h22222222; end
        fork send_cmd(4, 32'd5, 32'd0, 1'b0, -1, 1'b0); feed(2, -1, 0); join
        @(negedge ap_clk);
        ap_rst = 1'b1;
        @(posedge ap_clk); #1;
        chk("midrst_cmd_ready", bus.cmd_ready, 1);
        chk("midrst_op_ready", bus.op_ready, 0);
        chk("midrst_res_valid", bus.res_valid, 0);
        chk("midrst_mac_a", bus.mac_a, 0);
        chk("midrst_res_data", bus.res_data, 0);
        @(negedge ap_clk);
        ap_rst = 1'b0;
        repeat (4) @(negedge ap_clk);
        chk("midrst_no_res", bus.res_valid, 0);
        chk("midrst_two_starts", nstart - s, 2);
        va[0] = 32'h01020304; vb[0] = 32'h05060708;
        fork send_cmd(1, 32'd7, 32'd77, 1'b0, 5, 1'b1); feed(1, -1, 0); join
        drain();

`ifdef MAC_DOT_DRIVER_TIMEOUT_EN
        // Silent core: WAIT entered at cycle 3, error result 16 cycles later.
        core_en = 1'b0;
        va[0] = 32'h01010101; vb[0] = 32'h01010101;
        fork send_cmd(1, 32'h12345678, 32'h12345678, 1'b1, 19, 1'b1); feed(1, -1, 0); join
        drain();
        chk("tmo_err_cleared", bus.res_err, 0);
        core_en = 1'b1;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end
endmodule

// File: doc/mac_dot_driver.md
MAC_DOT_DRIVER -- requirements
Module: mac_dot_driver

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYC, 15, WAIT-state cycle limit (used only with MAC_DOT_DRIVER_TIMEOUT_EN).
REQ-002 SHALL have a single clock and a synchronous active-high reset; every flop updates on the rising edge of ap_clk.
REQ-003 ap_clk  in  1  sole clock.
REQ-004 ap_rst  in  1  synchronous active-high reset.
REQ-005 cmd_valid / cmd_ready  in / out  1 / 1  command handshake.
REQ-006 cmd_len  in  8  number of 4-lane beats (0..255).
REQ-007 cmd_acc_init  in  32  initial accumulator value.
REQ-008 op_valid / op_ready  in / out  1 / 1  operand handshake.
REQ-009 op_a / op_b  in  32 / 32  packed uint8 lanes; lane i = bits [8i+7:8i].
REQ-010 mac_ce, mac_continue  out  1  MAC core enable and continue; both tied to 1 when not in reset.
REQ-011 mac_start  out  1  core ap_start.
REQ-012 mac_a / mac_b  out  32 / 32  lanes to core a0..a3 / b0..b3.
REQ-013 mac_acc_in  out  32  accumulator to core.
REQ-014 mac_acc_out  in  32  core result.
REQ-015 mac_acc_vld  in  1  core acc_ap_vld / ap_done pulse.
REQ-016 res_valid / res_ready  out / in  1 / 1  result handshake.
REQ-017 res_data  out  32  final accumulator.
REQ-018 res_err  out  1  timeout flag (constant 0 without MAC_DOT_DRIVER_TIMEOUT_EN).

Function
REQ-019 SHALL implement FSM states IDLE, FETCH, ISSUE, WAIT, DONE.
REQ-020 IDLE: cmd_ready=1; on cmd_valid, latch cmd_len into beat counter and cmd_acc_init into acc_reg; go to FETCH, or to DONE if cmd_len=0.
REQ-021 FETCH: op_ready=1; on op_valid, latch op_a/op_b into operand registers and go to ISSUE; stall indefinitely while op_valid=0.
REQ-022 ISSUE: mac_start=1 for exactly one cycle; go to WAIT.
REQ-023 mac_a, mac_b and mac_acc_in SHALL be driven from registers and held stable from ISSUE through the cycle mac_acc_vld is sampled high.
REQ-024 mac_acc_in SHALL equal acc_reg.
REQ-025 WAIT: on mac_acc_vld=1, acc_reg <= mac_acc_out and decrement the beat counter; go to DONE if the counter reaches 0, else FETCH.
REQ-026 The core returns mac_acc_vld two cycles after mac_start, so a beat with op_valid held high SHALL take 4 cycles (FETCH, ISSUE, WAIT, WAIT).
REQ-027 With cmd accepted at cycle 0 and op_valid held high, res_valid SHALL assert at cycle 4*cmd_len+1; with cmd_len=0, at cycle 1 with res_data=cmd_acc_init.
REQ-028 DONE: res_valid=1 and res_data=acc_reg, held stable until res_ready=1; then go to IDLE.
REQ-029 A mac_acc_vld pulse outside WAIT SHALL be ignored.
REQ-030 cmd_ready and op_ready SHALL be 0 in all states other than IDLE and FETCH respectively.
REQ-031 Accumulation SHALL wrap modulo 2^32; no saturation.

Reset
REQ-032 ap_rst SHALL force IDLE and clear acc_reg, the beat counter, operand registers and the timeout counter.
REQ-033 During and after reset, the outputs SHALL be: mac_start=0, res_valid=0, res_err=0, op_ready=0, mac_a=mac_b=mac_acc_in=0, res_data=0; cmd_ready SHALL be 1 in the first cycle after reset deasserts.
REQ-034 Reset mid-command SHALL discard the partial result with no res_valid.

Configuration
REQ-035 Macro MAC_DOT_DRIVER_TIMEOUT_EN defined: a counter SHALL run in WAIT; if mac_acc_vld is absent for TIMEOUT_CYC+1 consecutive cycles, go to DONE with res_err=1 and res_data=acc_reg. res_err clears on the res handshake.
REQ-036 Macro MAC_DOT_DRIVER_TIMEOUT_EN undefined: no counter; WAIT waits forever; res_err=0.

Verification
REQ-037 cmd_len=1, acc_init=0, op_a=0x04030201, op_b=0x01010101 (core model) -> res_data=10 at cycle 5, res_err=0.
REQ-038 cmd_len=3, acc_init=100, every op_a=op_b=0x02020202 -> res_data=148 at cycle 13.
REQ-039 cmd_len=0, acc_init=0xDEADBEEF -> res_valid at cycle 1 with res_data=0xDEADBEEF, mac_start never asserted.
REQ-040 cmd_len=2, op_valid gapped 5 cycles before beat 2, res_ready held 0 for 3 cycles -> correct sum; res_data stable while stalled; mac_a/mac_b/mac_acc_in stable from ISSUE through mac_acc_vld.
REQ-041 ap_rst asserted in WAIT of beat 2 of 4 -> IDLE next cycle, no res_valid; a new cmd_len=1 command then completes correctly.
REQ-042 MAC_DOT_DRIVER_TIMEOUT_EN defined, core model never pulses mac_acc_vld -> res_valid with res_err=1 exactly 16 cycles after entering WAIT.
